// File: rtl/dmem_banked_pkg.sv
// Shared types and defaults for the byte-banked data memory.
// Size and state encodings used by the top and the bench.
package dmem_banked_pkg;

  localparam int unsigned DMEM_XLEN   = 32;
  localparam int unsigned DMEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    SzB   = 2'd0,
    SzH   = 2'd1,
    SzW   = 2'd2,
    SzRsv = 2'd3
  } size_e;

  typedef enum logic {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

  // Access width in bytes; the reserved encoding maps to 8 and is rejected upstream.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of the data memory: 8-bit x Depth synchronous single-port RAM.
// A write returns the old contents on the same cycle's read port.
module dmem_lane_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_banked.sv
// Byte-banked data memory: one load/store per cycle, any alignment, valid/ready on both sides.
// Lane k holds bytes whose address mod LANES equals k; unaligned accesses spill into row+1.
module dmem_banked
  import dmem_banked_pkg::*;
#(
  parameter int unsigned XLEN        = DMEM_XLEN,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter string       INIT_PREFIX = "dmem"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned SelW  = $clog2(LANES);
  localparam int unsigned RowW  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(DEPTH * LANES - 1);

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q;
  logic [RowW-1:0] row_q;
  logic [1:0]      size_q;
  logic            uns_q, we_q, err_q;

  logic            accept;
  logic [SelW-1:0] req_sel;
  logic [RowW-1:0] req_row;
  logic [3:0]      req_bytes;
  logic [ADDR_W:0] req_last;
  logic            req_err;

  assign req_sel   = req_addr[SelW-1:0];
  assign req_row   = req_addr[SelW +: RowW];
  assign req_bytes = size_bytes(req_size);
  // One extra bit so an access at the top of the address space cannot wrap past the check.
  assign req_last  = {1'b0, req_addr} + (ADDR_W + 1)'(req_bytes) - (ADDR_W + 1)'(1);
  assign req_err   = (req_size == SzRsv) || (32'(req_bytes) > LANES) || (req_last > LastAddr);

  assign req_ready  = (state_q == StIdle) || resp_ready;
  assign resp_valid = (state_q == StResp);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      StResp: if (resp_ready) state_d = accept ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      row_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q  <= req_sel;
        row_q  <= req_row;
        size_q <= req_size;
        uns_q  <= req_unsigned;
        we_q   <= req_we;
        err_q  <= req_err;
      end
    end
  end

  // Without a new accept the lanes keep re-reading the held rows, so q is stable under stall.
  logic [SelW-1:0] addr_sel;
  logic [RowW-1:0] addr_row;
  logic [7:0]      lane_q [LANES];

  assign addr_sel = accept ? req_sel : sel_q;
  assign addr_row = accept ? req_row : row_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [SelW-1:0] off;
    logic [RowW-1:0] lane_addr;
    logic            lane_we;
    logic [7:0]      lane_wdata;

    assign off        = SelW'(k) - req_sel;
    assign lane_addr  = (SelW'(k) < addr_sel) ? addr_row + RowW'(1) : addr_row;
    assign lane_we    = accept && req_we && !req_err && (4'(off) < req_bytes);
    assign lane_wdata = req_wdata[8*off +: 8];

    dmem_lane_ram #(
      .Depth (DEPTH)
    ) u_lane_ram (
      .clk_i   (clk),
      .we_i    (lane_we),
      .addr_i  (lane_addr),
      .wdata_i (lane_wdata),
      .rdata_o (lane_q[k])
    );
  end

  logic [XLEN-1:0] load_data;
  logic [3:0]      held_bytes;
  logic            sign;

  always_comb begin
    held_bytes = size_bytes(size_q);
    load_data  = '0;
    sign       = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (4'(i) < held_bytes) begin
        load_data[8*i +: 8] = lane_q[sel_q + SelW'(i)];
      end
      if (4'(i) == held_bytes - 4'd1) begin
        sign = load_data[8*i + 7];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if ((4'(i) >= held_bytes) && sign && !uns_q) begin
        load_data[8*i +: 8] = 8'hFF;
      end
    end
  end

  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : '0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_banked.sv
// Scoreboard bench for dmem_banked: expectations are queued at accept and popped on response.
module tb_dmem_banked;
  import dmem_banked_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_BYTES = DEPTH * 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  always #5 clk = ~clk;

  dmem_banked #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] model [MEM_BYTES];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    longint a  = longint'(addr);
    longint nb = longint'(1) << size;
    return (size == 2'd3) || (a + nb - 1 > longint'(MEM_BYTES - 1));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int          nb = 1 << size;
    int          a  = int'(addr);
    logic [31:0] v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = model[a + i];
    if (!uns && v[8*nb - 1]) begin
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    bit accepted = 1'b0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    if (!accepted) begin
      check("req_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    if (we && !model_err(size, addr)) begin
      for (int i = 0; i < (1 << size); i++) model[int'(addr) + i] = wdata[8*i +: 8];
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic send_model(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d = '0;
    logic        e = model_err(size, addr);
    if (!e && !we) d = model_load(size, uns, addr);
    send(we, size, uns, addr, wdata, d, e);
  endtask

  always @(negedge clk) begin
    if (reset && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdata", resp_rdata, mon_e.rdata);
        check("err", resp_err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3 reset = 1'b0;
    #10;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Known contents everywhere so the model can track random traffic.
    for (int r = 0; r < int'(DEPTH); r++) send_model(1'b1, SzW, 1'b0, 32'(4 * r), 32'h0);

    send(1'b1, SzW, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, SzW, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    check("load_latency_valid", resp_valid, 1);

    send(1'b1, SzW, 1'b0, 32'h0E, 32'h11223344, 32'h0, 1'b0);
    send(1'b0, SzW, 1'b0, 32'h0E, 32'h0, 32'h11223344, 1'b0);
    send(1'b0, SzB, 1'b1, 32'h0E, 32'h0, 32'h00000044, 1'b0);
    send(1'b0, SzB, 1'b1, 32'h11, 32'h0, 32'h00000011, 1'b0);

    send(1'b1, SzB, 1'b0, 32'h21, 32'h00000080, 32'h0, 1'b0);
    send(1'b0, SzB, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    send(1'b0, SzB, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0);
    send(1'b1, SzB, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0);
    send(1'b0, SzH, 1'b0, 32'h20, 32'h0, 32'hFFFF8000, 1'b0);

    send(1'b1, SzW, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, SzW, 1'b0, 32'hFE, 32'h0, 32'h0, 1'b1);
    send(1'b1, SzW, 1'b0, 32'hFD, 32'h01020304, 32'h0, 1'b1);
    send(1'b0, SzW, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, SzH, 1'b0, 32'hFE, 32'h0, 32'hFFFFCAFE, 1'b0);
    send(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);

    // Backpressure: second load must wait while the first response is held.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    send(1'b0, SzW, 1'b0, 32'h10, 32'h0, 32'hDEAD1122, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SzW;
    req_addr  = 32'hFC;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_resp_valid", resp_valid, 1);
      check("bp_rdata_stable", resp_rdata, 32'hDEAD1122);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", req_ready, 1);
    sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", resp_valid, 1);

    // Reset while a response is held.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    send_model(1'b0, SzW, 1'b0, 32'h20, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_err", resp_err, 0);
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    resp_ready = 1'b1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", resp_valid, 0);
    send(1'b0, SzW, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, SzW, 1'b0, 32'h10, 32'h0, 32'hDEAD1122, 1'b0);

    for (int n = 0; n < 80; n++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      send_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, MEM_BYTES + 7)), $urandom);
    end

    resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
